// File: rtl/gbox_rate_clk_gen_if.sv
// Signal bundle between a gearbox lane and its rate clock generator.
// The generator connects to the slave modport and the lane logic to the master modport.
interface gbox_rate_clk_gen_if #(
    parameter int CNT_W = 5
);
    logic             pll_lock;
    logic             cfg_done;
    logic             cfg_bypass;
    logic             cfg_chan_master;
    logic [CNT_W-1:0] rate_sel;
    logic             fast_clk_sync_in;
    logic             core_clk;
    logic             word_load_en;
    logic             fast_clk_sync_out;
    logic             diff_clk;
    logic             gen_active;
    logic             rate_ack;
    logic             align_err;

    modport master (
        output pll_lock, cfg_done, cfg_bypass, cfg_chan_master, rate_sel, fast_clk_sync_in,
        input  core_clk, word_load_en, fast_clk_sync_out, diff_clk, gen_active, rate_ack, align_err
    );

    modport slave (
        input  pll_lock, cfg_done, cfg_bypass, cfg_chan_master, rate_sel, fast_clk_sync_in,
        output core_clk, word_load_en, fast_clk_sync_out, diff_clk, gen_active, rate_ack, align_err
    );
endinterface

// File: rtl/gbox_rate_clk_gen.sv
// Gearbox rate clock generator: derives core_clk, word_load_en and lane sync from fast_clk,
// with PLL-lock filtering, boundary-only rate changes and master/slave lane alignment.
module gbox_rate_clk_gen #(
    parameter int CNT_W      = 5,
    parameter int LOCK_CNT_W = 5,
    parameter int ALIGN_TO_W = 8
) (
    input  logic              fast_clk,
    input  logic              reset_n,
    gbox_rate_clk_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_WAIT = 2'd1,
        ALIGN     = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]      R_MIN    = CNT_W'(2);
    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = {LOCK_CNT_W{1'b1}};
    localparam logic [ALIGN_TO_W-1:0] TO_MAX   = {ALIGN_TO_W{1'b1}};

    state_t                  state_r, state_s;
    logic                    lock_meta_r, lock_sync_r;
    logic [LOCK_CNT_W-1:0]   lock_cnt_r, lock_cnt_s, lock_inc_s;
    logic [ALIGN_TO_W-1:0]   to_cnt_r, to_cnt_s, to_inc_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s, ra_r, ra_s, rq_s, last_s;
    logic                    err_s, ack_s, run_s, core_s, wle_s, diff_s;
    logic                    core_clk_r, wle_r, sync_out_r, diff_r, active_r, ack_r, err_r;

    // ceil(r/2) without widening: r>>1 plus the odd bit
    function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] r);
        return {1'b0, r[CNT_W-1:1]} + {{(CNT_W-1){1'b0}}, r[0]};
    endfunction

    assign rq_s       = (bus.rate_sel < R_MIN) ? R_MIN : bus.rate_sel;
    assign last_s     = ra_r - CNT_W'(1);
    assign lock_inc_s = lock_cnt_r + LOCK_CNT_W'(1);
    assign to_inc_s   = to_cnt_r + ALIGN_TO_W'(1);

    // Bring-up FSM, word counter, ratio update and alignment error tracking
    always_comb begin
        state_s    = state_r;
        lock_cnt_s = {LOCK_CNT_W{1'b0}};
        to_cnt_s   = {ALIGN_TO_W{1'b0}};
        cnt_s      = cnt_r;
        ra_s       = ra_r;
        err_s      = err_r;
        ack_s      = 1'b0;
        if (!bus.cfg_done || bus.cfg_bypass || !lock_sync_r) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
            err_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = LOCK_WAIT;
                end
                LOCK_WAIT: begin
                    if (lock_inc_s == LOCK_MAX) begin
                        state_s = ALIGN;
                        ra_s    = rq_s;
                    end else begin
                        lock_cnt_s = lock_inc_s;
                    end
                end
                ALIGN: begin
                    cnt_s = {CNT_W{1'b0}};
                    if (bus.cfg_chan_master || bus.fast_clk_sync_in) begin
                        state_s = RUN;
                    end else if (to_inc_s == TO_MAX) begin
                        state_s = RUN;
                        err_s   = 1'b1;
                    end else begin
                        to_cnt_s = to_inc_s;
                    end
                end
                RUN: begin
                    if (cnt_r == last_s) begin
                        cnt_s = {CNT_W{1'b0}};
                        if (rq_s != ra_r) begin
                            ra_s  = rq_s;
                            ack_s = 1'b1;
                        end else begin
                            ra_s = ra_r;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                    // Slave resync: a master pulse coinciding with our own wrap is the aligned case
                    if (!bus.cfg_chan_master && bus.fast_clk_sync_in) begin
                        cnt_s = {CNT_W{1'b0}};
                        if (cnt_r != last_s) begin
                            err_s = 1'b1;
                        end else begin
                            err_s = err_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output values for the coming cycle, so the registered outputs track the registered count
    always_comb begin
        run_s = (state_s == RUN);
        if (run_s) begin
            core_s = (cnt_s < half_up(ra_s));
            wle_s  = (cnt_s == (ra_s - CNT_W'(1)));
        end else begin
            core_s = 1'b1;
            wle_s  = 1'b0;
        end
        if (bus.cfg_done) begin
            diff_s = ~diff_r;
        end else begin
            diff_s = 1'b0;
        end
    end

    // PLL lock synchroniser, FSM state, counters and active ratio
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
            state_r     <= IDLE;
            lock_cnt_r  <= {LOCK_CNT_W{1'b0}};
            to_cnt_r    <= {ALIGN_TO_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ra_r        <= R_MIN;
        end else begin
            lock_meta_r <= bus.pll_lock;
            lock_sync_r <= lock_meta_r;
            state_r     <= state_s;
            lock_cnt_r  <= lock_cnt_s;
            to_cnt_r    <= to_cnt_s;
            cnt_r       <= cnt_s;
            ra_r        <= ra_s;
        end
    end

    // Registered outputs
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            core_clk_r <= 1'b1;
            wle_r      <= 1'b0;
            sync_out_r <= 1'b0;
            diff_r     <= 1'b0;
            active_r   <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            core_clk_r <= core_s;
            wle_r      <= wle_s;
            sync_out_r <= wle_s & bus.cfg_chan_master;
            diff_r     <= diff_s;
            active_r   <= run_s;
            ack_r      <= ack_s;
            err_r      <= err_s;
        end
    end

    assign bus.core_clk          = core_clk_r;
    assign bus.word_load_en      = wle_r;
    assign bus.fast_clk_sync_out = sync_out_r;
    assign bus.diff_clk          = diff_r;
    assign bus.gen_active        = active_r;
    assign bus.rate_ack          = ack_r;
    assign bus.align_err         = err_r;
endmodule

// File: tb/tb_gbox_rate_clk_gen.sv
// Bench for gbox_rate_clk_gen: a master and a slave lane, expected per-cycle outputs
// queued as stimulus is applied and compared on the falling edge.
module tb_gbox_rate_clk_gen;
    localparam int CNT_W = 5;
    // Output vector bit order: core_clk, word_load_en, sync_out, diff_clk, gen_active, rate_ack, align_err
    localparam logic [6:0] MSK_ALL    = 7'b1111111;
    localparam logic [6:0] MSK_NODIFF = 7'b1110111;
    localparam logic [6:0] RST_OUTS   = 7'b1000000;

    typedef struct packed {
        logic       lane;
        logic [6:0] val;
        logic [6:0] msk;
    } exp_t;

    typedef struct packed {
        logic [CNT_W-1:0] rate_sel;
        logic [7:0]       period;
        logic [7:0]       high;
    } vec_t;

    logic  fast_clk = 1'b0;
    logic  reset_n  = 1'b0;
    logic  s_inj    = 1'b0;
    logic  s_link   = 1'b0;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    k        = 0;
    string cur_name = "reset";
    exp_t  sb_q[$];
    vec_t  vt[7];
    logic [6:0] m_outs, s_outs;

    gbox_rate_clk_gen_if #(.CNT_W(CNT_W)) m_if ();
    gbox_rate_clk_gen_if #(.CNT_W(CNT_W)) s_if ();

    assign s_if.fast_clk_sync_in = s_inj | (s_link & m_if.fast_clk_sync_out);

    gbox_rate_clk_gen #(.CNT_W(CNT_W), .LOCK_CNT_W(5), .ALIGN_TO_W(8)) u_master (
        .fast_clk (fast_clk),
        .reset_n  (reset_n),
        .bus      (m_if)
    );

    gbox_rate_clk_gen #(.CNT_W(CNT_W), .LOCK_CNT_W(5), .ALIGN_TO_W(8)) u_slave (
        .fast_clk (fast_clk),
        .reset_n  (reset_n),
        .bus      (s_if)
    );

    assign m_outs = {m_if.core_clk, m_if.word_load_en, m_if.fast_clk_sync_out, m_if.diff_clk,
                     m_if.gen_active, m_if.rate_ack, m_if.align_err};
    assign s_outs = {s_if.core_clk, s_if.word_load_en, s_if.fast_clk_sync_out, s_if.diff_clk,
                     s_if.gen_active, s_if.rate_ack, s_if.align_err};

    always #5 fast_clk = ~fast_clk;

    task automatic check(input string name, input logic lane, input logic [6:0] act, input logic [6:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s lane %0d cycle %0d: actual %b required %b", name, lane, k, act, req);
        end
    endtask

    // Scoreboard: drain everything expected for this cycle
    initial begin
        forever begin
            @(negedge fast_clk);
            while (sb_q.size() > 0) begin : drain
                exp_t e;
                e = sb_q.pop_front();
                check(cur_name, e.lane, (e.lane ? s_outs : m_outs) & e.msk, e.val & e.msk);
            end
        end
    end

    task automatic step();
        @(posedge fast_clk);
        #1;
        k++;
    endtask

    task automatic push(input logic lane, input logic [6:0] val, input logic [6:0] msk);
        exp_t e;
        e.lane = lane;
        e.val  = val;
        e.msk  = msk;
        sb_q.push_back(e);
    endtask

    task automatic push_idle(input logic lane, input logic err, input logic [6:0] msk);
        push(lane, {1'b1, 1'b0, 1'b0, k[0], 1'b0, 1'b0, err}, msk);
    endtask

    task automatic push_run(input logic lane, input int ra, input int cnt, input logic ack,
                            input logic err, input logic mst, input logic [6:0] msk);
        logic wl;
        wl = (cnt == ra - 1);
        push(lane, {(cnt < (ra + 1) / 2), wl, wl & mst, k[0], 1'b1, ack, err}, msk);
    endtask

    task automatic run_cycles(input logic lane, input int ra, input int start, input int n,
                              input logic err, input logic mst);
        for (int c = 0; c < n; c++) begin
            step();
            push_run(lane, ra, (start + c) % ra, 1'b0, err, mst, MSK_ALL);
        end
    endtask

    task automatic idle_cycles(input int n, input logic both);
        for (int c = 0; c < n; c++) begin
            step();
            push_idle(1'b0, 1'b0, MSK_ALL);
            if (both) push_idle(1'b1, 1'b0, MSK_ALL);
        end
    endtask

    // Asserted between edges and checked before the next edge, so the clear must be asynchronous
    task automatic do_reset();
        @(posedge fast_clk);
        #1;
        reset_n = 1'b0;
        @(negedge fast_clk);
        check("reset_master", 1'b0, m_outs, RST_OUTS);
        check("reset_slave", 1'b1, s_outs, RST_OUTS);
        @(posedge fast_clk);
        #1;
        reset_n = 1'b1;
        k = 0;
    endtask

    initial begin
        vt[0] = '{5'd4,  8'd4,  8'd2};
        vt[1] = '{5'd5,  8'd5,  8'd3};
        vt[2] = '{5'd2,  8'd2,  8'd1};
        vt[3] = '{5'd0,  8'd2,  8'd1};
        vt[4] = '{5'd1,  8'd2,  8'd1};
        vt[5] = '{5'd3,  8'd3,  8'd2};
        vt[6] = '{5'd31, 8'd31, 8'd16};

        m_if.pll_lock = 1'b1; m_if.cfg_done = 1'b1; m_if.cfg_bypass = 1'b0;
        m_if.cfg_chan_master = 1'b1; m_if.rate_sel = 5'd4; m_if.fast_clk_sync_in = 1'b0;
        s_if.pll_lock = 1'b1; s_if.cfg_done = 1'b0; s_if.cfg_bypass = 1'b0;
        s_if.cfg_chan_master = 1'b0; s_if.rate_sel = 5'd4;

        // Master bring-up and steady-state patterns for each ratio
        for (int i = 0; i < 7; i++) begin
            cur_name = $sformatf("ratio_sel%0d", vt[i].rate_sel);
            m_if.rate_sel = vt[i].rate_sel;
            do_reset();
            idle_cycles(34, 1'b0);
            for (int c = 0; c < 3 * int'(vt[i].period); c++) begin
                int p;
                logic wl;
                step();
                p  = c % int'(vt[i].period);
                wl = (p == int'(vt[i].period) - 1);
                push(1'b0, {(p < int'(vt[i].high)), wl, wl, k[0], 1'b1, 1'b0, 1'b0}, MSK_ALL);
            end
        end

        // Rate change 4 -> 6 requested at cnt=1
        cur_name = "rate_change";
        m_if.rate_sel = 5'd4;
        do_reset();
        idle_cycles(34, 1'b0);
        run_cycles(1'b0, 4, 0, 6, 1'b0, 1'b1);
        m_if.rate_sel = 5'd6;
        run_cycles(1'b0, 4, 2, 2, 1'b0, 1'b1);
        step();
        push_run(1'b0, 6, 0, 1'b1, 1'b0, 1'b1, MSK_ALL);
        run_cycles(1'b0, 6, 1, 11, 1'b0, 1'b1);

        // One-cycle pll_lock drop in RUN, then full relock
        cur_name = "lock_drop";
        m_if.rate_sel = 5'd4;
        do_reset();
        idle_cycles(34, 1'b0);
        run_cycles(1'b0, 4, 0, 5, 1'b0, 1'b1);
        m_if.pll_lock = 1'b0;
        step();
        m_if.pll_lock = 1'b1;
        push_run(1'b0, 4, 1, 1'b0, 1'b0, 1'b1, MSK_ALL);
        step();
        push_run(1'b0, 4, 2, 1'b0, 1'b0, 1'b1, MSK_ALL);
        idle_cycles(33, 1'b0);
        run_cycles(1'b0, 4, 0, 8, 1'b0, 1'b1);

        // Master/slave chain, perturbed slave, error cleared by cfg_done low
        cur_name = "chain";
        s_if.cfg_done = 1'b1;
        s_link = 1'b1;
        do_reset();
        idle_cycles(34, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            push_run(1'b0, 4, c, 1'b0, 1'b0, 1'b1, MSK_ALL);
            push_idle(1'b1, 1'b0, MSK_ALL);
        end
        for (int c = 0; c < 11; c++) begin
            step();
            push_run(1'b0, 4, c % 4, 1'b0, 1'b0, 1'b1, MSK_ALL);
            push_run(1'b1, 4, c % 4, 1'b0, 1'b0, 1'b0, MSK_ALL);
        end
        s_inj = 1'b1;
        step();
        s_inj = 1'b0;
        push_run(1'b0, 4, 3, 1'b0, 1'b0, 1'b1, MSK_ALL);
        push_run(1'b1, 4, 0, 1'b0, 1'b1, 1'b0, MSK_ALL);
        for (int c = 0; c < 8; c++) begin
            step();
            push_run(1'b0, 4, c % 4, 1'b0, 1'b0, 1'b1, MSK_ALL);
            push_run(1'b1, 4, c % 4, 1'b0, 1'b1, 1'b0, MSK_ALL);
        end
        s_if.cfg_done = 1'b0;
        step();
        push_run(1'b0, 4, 0, 1'b0, 1'b0, 1'b1, MSK_ALL);
        push_idle(1'b1, 1'b0, MSK_NODIFF);
        s_if.cfg_done = 1'b1;
        step();
        push_run(1'b0, 4, 1, 1'b0, 1'b0, 1'b1, MSK_ALL);
        push_idle(1'b1, 1'b0, MSK_NODIFF);

        // Slave with no sync: alignment timeout then free-run
        cur_name = "align_timeout";
        m_if.cfg_done = 1'b0;
        s_link = 1'b0;
        do_reset();
        for (int c = 0; c < 288; c++) begin
            step();
            push_idle(1'b1, 1'b0, MSK_ALL);
        end
        run_cycles(1'b1, 4, 0, 8, 1'b1, 1'b0);

        @(posedge fast_clk);
        @(negedge fast_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gbox_rate_clk_gen.md
Name:
gbox_rate_clk_gen

Overview:
- Parametrised next-generation gearbox rate clock generator, running entirely in the fast_clk domain.
- Derives core_clk, word_load_en and the lane-sync pulse from fast_clk with a configurable counter width.
- Adds features the previous generation lacks:
  - explicit bring-up state machine;
  - PLL-lock filtering with immediate drop-out;
  - glitch-free rate changes at word boundaries;
  - correct duty for odd ratios;
  - slave alignment timeout and misalignment detection.
- Sits once per gearbox lane; master/slave lanes are chained via fast_clk_sync_out to fast_clk_sync_in.

Parameters:
- CNT_W, 5: width of rate_sel and of the word counter; legal ratios R = 2 .. 2^CNT_W-1.
- LOCK_CNT_W, 5: PLL lock filter; requires 2^LOCK_CNT_W-1 consecutive cycles of pll_lock high.
- ALIGN_TO_W, 8: slave alignment timeout is 2^ALIGN_TO_W-1 cycles.

Ports:
- fast_clk  in  1  fast serial clock; sole clock.
- reset_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL lock, asynchronous to fast_clk, double-flopped internally.
- cfg_done  in  1  configuration complete.
- cfg_bypass  in  1  gearbox bypass; holds the generator idle.
- cfg_chan_master  in  1  1 = master lane, 0 = slave lane.
- rate_sel  in  CNT_W  requested ratio R.
- fast_clk_sync_in  in  1  sync pulse from the master lane.
- core_clk  out  1  divided clock.
- word_load_en  out  1  one-cycle pulse on the last fast cycle of each word.
- fast_clk_sync_out  out  1  sync pulse to slave lanes.
- diff_clk  out  1  fast_clk/2 toggle used for DDR select.
- gen_active  out  1  1 while in RUN.
- rate_ack  out  1  one-cycle pulse when a new ratio takes effect.
- align_err  out  1  sticky alignment error.

Behaviour:
- Reset values: core_clk=1; all other outputs 0; state=IDLE; cnt=0; active ratio Ra=2. All outputs are registered.
- Ratio clamp: effective request Rq = max(rate_sel,2). No arithmetic wraps: R-1 and ceil(R/2) are computed in CNT_W bits from Rq ≥ 2.
- States:
  - IDLE: entered whenever cfg_done=0, cfg_bypass=1 or synced pll_lock=0 (highest priority, from any state). Moves to LOCK_WAIT when all three conditions are clear.
  - LOCK_WAIT: lock counter increments while synced pll_lock=1 and restarts at 0 when it drops. At 2^LOCK_CNT_W-1, go to ALIGN and latch Ra=Rq.
  - ALIGN:
    - Master: go to RUN on the next cycle.
    - Slave: go to RUN on the cycle after sync_in is sampled high.
    - Slave timeout: if the timeout counter reaches 2^ALIGN_TO_W-1, set align_err and enter RUN free-running.
  - RUN: cnt counts 0..Ra-1 and wraps to 0. The first RUN cycle has cnt=0.
- RUN outputs, per cycle, as a function of cnt:
  - core_clk=1 when cnt < ceil(Ra/2), else 0. Odd R gives high for one extra cycle, e.g. R=5 gives 3 high, 2 low.
  - word_load_en=1 when cnt==Ra-1.
  - fast_clk_sync_out=1 when cnt==Ra-1, master only; a slave drives 0.
  - gen_active=1.
- Non-RUN outputs: core_clk=1; word_load_en, fast_clk_sync_out, gen_active and rate_ack are 0.
- Slave resync in RUN: sync_in sampled high forces next cnt=0.
  - If the slave's own cnt ≠ Ra-1 at that edge, set align_err.
  - sync_in and natural wrap at the same edge is correct alignment: no error.
- Rate change:
  - Rq ≠ Ra is sampled only at the edge where cnt==Ra-1.
  - Ra takes Rq from the next cnt=0; rate_ack pulses in that cnt=0 cycle.
  - A word is never truncated. A request changing mid-word is evaluated only at the boundary.
- align_err: sticky; cleared only by reset_n or by IDLE entry.
- diff_clk: toggles every cycle while cfg_done=1 regardless of state/bypass/lock; forced 0 while cfg_done=0.
- Lock loss in RUN:
  - Synced pll_lock low takes the state to IDLE on the next edge, mid-word allowed.
  - Outputs take their non-RUN values; Ra is retained until the next lock acquisition.
- Reset mid-operation: all flops return to reset values asynchronously. There is no partial word output after reset release.
- Latency:
  - reset_n release to first word_load_en (master, pll_lock stable high, R=4): 2 sync + 31 lock + 1 ALIGN + 4 = 38 cycles.

Test Plan:
- Master bring-up, R=4, LOCK_CNT_W=5, pll_lock high from reset → gen_active rises after 34 cycles; core_clk 1100 repeating; word_load_en and sync_out high every 4th cycle at cnt=3.
- R=5 and R=2 → core_clk patterns 11100 and 10; rate_sel=0 or 1 behaves exactly as R=2.
- Rate change 4→6 asserted at cnt=1 → current word completes 4 cycles; rate_ack pulses at the next cnt=0; following words are 6 cycles, core_clk 111000.
- Master and slave chained, slave perturbed by one extra sync_in at cnt=2 → slave realigns to the master next cycle, align_err=1; align_err stays 1 until cfg_done is toggled low.
- Slave with sync_in tied 0, ALIGN_TO_W=8 → after 255 ALIGN cycles align_err=1 and gen_active=1 (free-run).
- pll_lock drops for 1 cycle mid-word in RUN → IDLE (core_clk=1, gen_active=0); relock requires the full 31-cycle filter; diff_clk keeps toggling throughout.
